// File: rtl/alu_flags_stage.sv
// ALU result/flag commit stage: conditional flag update plus a
// two-entry result FIFO feeding writeback.
module alu_flags_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Y,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             Negative,
  input  logic             Carry,
  input  logic             set_flags,
  input  logic [3:0]       cond,
  input  logic [3:0]       rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_write,
  output logic [3:0]       flags
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       rd;
    logic             wr;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     head;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [3:0] flags_q, flags_d;
  logic       acc, pop, pass;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    pass = 1'b1;
    case (cond)
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = c;
      4'h3: pass = !c;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = c && !z;
      4'h9: pass = !c || z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    flags_d  = flags_q;
    if (acc && !pop)
      count_d = count_q + 2'd1;
    else if (!acc && pop)
      count_d = count_q - 2'd1;
    if (acc)
      wr_ptr_d = ~wr_ptr_q;
    if (pop)
      rd_ptr_d = ~rd_ptr_q;
    if (acc && set_flags && pass)
      flags_d = {Negative, Zero, Carry, Overflow};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      flags_q  <= flags_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && acc)
      mem_q[wr_ptr_q] <= '{res: Y, rd: rd, wr: pass};
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_result = out_valid ? head.res : '0;
  assign out_rd     = out_valid ? head.rd : 4'd0;
  assign out_write  = out_valid ? head.wr : 1'b0;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_flags_stage.sv
// Directed self-checking bench for alu_flags_stage.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_alu_flags_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Y;
  logic        Zero, Overflow, Negative, Carry;
  logic        set_flags;
  logic [3:0]  cond;
  logic [3:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_write;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  alu_flags_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .Negative  (Negative),
    .Carry     (Carry),
    .set_flags (set_flags),
    .cond      (cond),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rd    (out_rd),
    .out_write (out_write),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] y, input logic [3:0] nzcv,
                       input logic sf, input logic [3:0] c,
                       input logic [3:0] r);
    in_valid  = 1'b1;
    Y         = y;
    Negative  = nzcv[3];
    Zero      = nzcv[2];
    Carry     = nzcv[1];
    Overflow  = nzcv[0];
    set_flags = sf;
    cond      = c;
    rd        = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); bad++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); bad++;
    end
    total++;
    if (flags !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000", flags); bad++;
    end
    total++;
    if ({out_result, out_rd, out_write} !== 37'd0) begin
      $display("FAIL reset_outputs_zero got=%h/%h/%b exp=0",
               out_result, out_rd, out_write); bad++;
    end
  endtask

  task automatic test_idle();
    drive(32'h55, 4'b1111, 1'b1, 4'hE, 4'd9);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    total++;
    if (flags !== 4'b0000 || out_valid !== 1'b0) begin
      $display("FAIL idle_no_change got=flags %b ov %b exp=0000 0",
               flags, out_valid); bad++;
    end
  endtask

  task automatic test_basic();
    drive(32'd0, 4'b0100, 1'b1, 4'hE, 4'd3);
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_result, out_rd, out_write} !== {1'b1, 32'd0, 4'd3, 1'b1}) begin
      $display("FAIL basic_head got=%b %h %h %b exp=1 0 3 1",
               out_valid, out_result, out_rd, out_write); bad++;
    end
    total++;
    if (flags !== 4'b0100) begin
      $display("FAIL basic_flags got=%b exp=0100", flags); bad++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL basic_pop got=%b exp=0", out_valid); bad++;
    end
  endtask

  task automatic test_cond();
    drive(32'd5, 4'b1000, 1'b1, 4'h1, 4'd1);
    step();
    in_valid = 1'b0;
    total++;
    if (out_write !== 1'b0 || out_result !== 32'd5) begin
      $display("FAIL ne_fail got=%b %h exp=0 5", out_write, out_result); bad++;
    end
    total++;
    if (flags !== 4'b0100) begin
      $display("FAIL ne_flags_hold got=%b exp=0100", flags); bad++;
    end
    drive(32'd7, 4'b0000, 1'b0, 4'h0, 4'd2);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_result, out_rd, out_write} !== {1'b1, 32'd7, 4'd2, 1'b1}) begin
      $display("FAIL eq_pass got=%b %h %h %b exp=1 7 2 1",
               out_valid, out_result, out_rd, out_write); bad++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL eq_count_kept got=%b exp=1", in_ready); bad++;
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    drive(32'd10, 4'b0000, 1'b0, 4'hE, 4'd4);
    step();
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL full_one_ready got=%b exp=1", in_ready); bad++;
    end
    drive(32'd11, 4'b0000, 1'b0, 4'hE, 4'd5);
    step();
    total++;
    if (in_ready !== 1'b0) begin
      $display("FAIL full_two_ready got=%b exp=0", in_ready); bad++;
    end
    drive(32'd12, 4'b0000, 1'b0, 4'hE, 4'd6);
    step();
    step();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_result !== 32'd10 || out_rd !== 4'd4) begin
      $display("FAIL full_stall got=%b %h %h exp=0 a 4",
               in_ready, out_result, out_rd); bad++;
    end
    out_ready = 1'b1;
    step();
    total++;
    if ({in_ready, out_valid, out_result, out_rd} !== {2'b11, 32'd11, 4'd5}) begin
      $display("FAIL full_second got=%b %b %h %h exp=1 1 b 5",
               in_ready, out_valid, out_result, out_rd); bad++;
    end
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_result !== 32'd0) begin
      $display("FAIL full_drained got=%b %h exp=0 0", out_valid, out_result); bad++;
    end
  endtask

  task automatic test_stream();
    drive(32'd100, 4'b0000, 1'b0, 4'hE, 4'd0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'd101 + i, 4'b0000, 1'b0, 4'hE, 4'(i + 1));
      total++;
      if (out_result !== 32'd100 + i || out_rd !== 4'(i)) begin
        $display("FAIL stream_%0d got=%h %h exp=%h %h", i, out_result,
                 out_rd, 32'd100 + i, 4'(i)); bad++;
      end
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        $display("FAIL stream_count_%0d got=%b %b exp=1 1", i, in_ready,
                 out_valid); bad++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (out_result !== 32'd110) begin
      $display("FAIL stream_last got=%h exp=6e", out_result); bad++;
    end
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL stream_empty got=%b exp=0", out_valid); bad++;
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(32'hFFFF_FFFE, 4'b1000, 1'b1, 4'hE, 4'd7);
    step();
    drive(32'd1, 4'b0000, 1'b0, 4'hB, 4'd8);
    step();
    in_valid = 1'b0;
    total++;
    if (flags !== 4'b1000) begin
      $display("FAIL b2b_flags got=%b exp=1000", flags); bad++;
    end
    total++;
    if (out_result !== 32'hFFFF_FFFE || out_write !== 1'b1) begin
      $display("FAIL b2b_first got=%h %b exp=fffffffe 1", out_result,
               out_write); bad++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if ({out_result, out_rd, out_write} !== {32'd1, 4'd8, 1'b1}) begin
      $display("FAIL b2b_lt_pass got=%h %h %b exp=1 8 1", out_result,
               out_rd, out_write); bad++;
    end
    drive(32'd2, 4'b0000, 1'b1, 4'hA, 4'd9);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_result, out_write} !== {32'd2, 1'b0} || flags !== 4'b1000) begin
      $display("FAIL ge_fail got=%h %b %b exp=2 0 1000", out_result,
               out_write, flags); bad++;
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_prio();
    drive(32'd20, 4'b0011, 1'b1, 4'hE, 4'd1);
    step();
    drive(32'd21, 4'b0000, 1'b0, 4'hE, 4'd2);
    step();
    total++;
    if (in_ready !== 1'b0 || flags !== 4'b0011) begin
      $display("FAIL prio_setup got=%b %b exp=0 0011", in_ready, flags); bad++;
    end
    reset = 1'b1;
    out_ready = 1'b1;
    drive(32'd22, 4'b0100, 1'b1, 4'hE, 4'd3);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, flags} !== {1'b0, 1'b1, 4'b0000}) begin
      $display("FAIL prio_reset got=%b %b %b exp=0 1 0000", out_valid,
               in_ready, flags); bad++;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Y = '0;
    {Zero, Overflow, Negative, Carry} = '0;
    set_flags = 1'b0;
    cond = 4'h0;
    rd = 4'h0;
    step();
    test_reset();
    test_idle();
    test_basic();
    test_cond();
    test_full();
    test_stream();
    test_back_to_back();
    test_reset_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
